// File: rtl/counter_sched.sv
// counter_sched: round-robin command scheduler for a shared 4-bit mode counter.
// Two requesters present (mode, data, len) commands; the winner owns the counter
// for an accept cycle, len enable cycles and one completion cycle.
module counter_sched #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_mode,
  input  logic [3:0]       req0_data,
  input  logic [LEN_W-1:0] req0_len,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_mode,
  input  logic [3:0]       req1_data,
  input  logic [LEN_W-1:0] req1_len,
  output logic             cnt_enable,
  output logic [1:0]       cnt_mode,
  output logic [3:0]       cnt_D,
  input  logic             cnt_rco,
  output logic             done,
  output logic             done_id,
  output logic             done_rco
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0]       MODE_LOAD = 2'b11;
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;   // also the owner of the active command
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             rco_seen_q, rco_seen_d;
  logic             cnt_enable_q, cnt_enable_d;
  logic [1:0]       cnt_mode_q, cnt_mode_d;
  logic [3:0]       cnt_d_q, cnt_d_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             done_rco_q, done_rco_d;

  logic             grant0, grant1;
  logic             hs0, hs1;
  logic [1:0]       sel_mode;
  logic [3:0]       sel_data;
  logic [LEN_W-1:0] sel_len;
  logic [LEN_W-1:0] eff_len;

  // Round-robin arbiter: a lone requester wins; on contention the requester
  // that was not granted last wins. Readiness only exists in IDLE.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = (state_q == ST_IDLE) && !reset && grant0;
    req1_ready = (state_q == ST_IDLE) && !reset && grant1;
    hs0        = req0_valid && req0_ready;
    hs1        = req1_valid && req1_ready;
  end

  // Select the winning command and derive its effective run length:
  // a load runs for one cycle, and a zero length behaves as one.
  always_comb begin
    if (hs1) begin
      sel_mode = req1_mode;
      sel_data = req1_data;
      sel_len  = req1_len;
    end else begin
      sel_mode = req0_mode;
      sel_data = req0_data;
      sel_len  = req0_len;
    end
    if (sel_mode == MODE_LOAD || sel_len == '0) begin
      eff_len = LEN_ONE;
    end else begin
      eff_len = sel_len;
    end
  end

  // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    rco_seen_d   = rco_seen_q;
    cnt_enable_d = 1'b0;
    cnt_mode_d   = cnt_mode_q;
    cnt_d_d      = cnt_d_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    done_rco_d   = done_rco_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hs0 || hs1) begin
          state_d      = ST_RUN;
          last_grant_d = hs1;
          remaining_d  = eff_len;
          rco_seen_d   = 1'b0;
          cnt_mode_d   = sel_mode;
          cnt_d_d      = sel_data;
          cnt_enable_d = 1'b1;
        end
      end

      ST_RUN: begin
        rco_seen_d = rco_seen_q | cnt_rco;
        if (remaining_q <= LEN_ONE) begin
          // Final enable cycle: the rco of this cycle still counts.
          state_d    = ST_DONE;
          done_d     = 1'b1;
          done_id_d  = last_grant_q;
          done_rco_d = rco_seen_q | cnt_rco;
        end else begin
          remaining_d  = remaining_q - LEN_ONE;
          cnt_enable_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset dominates and aborts any run.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      remaining_q  <= '0;
      rco_seen_q   <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_mode_q   <= 2'b00;
      cnt_d_q      <= 4'h0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      done_rco_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      rco_seen_q   <= rco_seen_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_mode_q   <= cnt_mode_d;
      cnt_d_q      <= cnt_d_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      done_rco_q   <= done_rco_d;
    end
  end

  assign cnt_enable = cnt_enable_q;
  assign cnt_mode   = cnt_mode_q;
  assign cnt_D      = cnt_d_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign done_rco   = done_rco_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed self-checking bench for counter_sched.
module tb_counter_sched;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [1:0]       req0_mode, req1_mode;
  logic [3:0]       req0_data, req1_data;
  logic [LEN_W-1:0] req0_len, req1_len;
  logic             cnt_enable;
  logic [1:0]       cnt_mode;
  logic [3:0]       cnt_D;
  logic             cnt_rco;
  logic             done, done_id, done_rco;

  int tests_run = 0;
  int tests_failed = 0;

  counter_sched #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_mode  (req0_mode),
    .req0_data  (req0_data),
    .req0_len   (req0_len),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_mode  (req1_mode),
    .req1_data  (req1_data),
    .req1_len   (req1_len),
    .cnt_enable (cnt_enable),
    .cnt_mode   (cnt_mode),
    .cnt_D      (cnt_D),
    .cnt_rco    (cnt_rco),
    .done       (done),
    .done_id    (done_id),
    .done_rco   (done_rco)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges and check the reset state.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_enable", cnt_enable, 0);
    check("rst_mode", cnt_mode, 0);
    check("rst_D", cnt_D, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_done_rco", done_rco, 0);
    reset = 1'b0;
  endtask

  // Present one command from requester n while the DUT is idle, check the
  // same-cycle ready, then scramble the fields after acceptance.
  task automatic issue(input int n, input logic [1:0] m, input logic [3:0] d,
                       input logic [LEN_W-1:0] l);
    if (n == 0) begin
      req0_valid = 1'b1; req0_mode = m; req0_data = d; req0_len = l;
    end else begin
      req1_valid = 1'b1; req1_mode = m; req1_data = d; req1_len = l;
    end
    #1;
    check("issue_ready0", req0_ready, (n == 0));
    check("issue_ready1", req1_ready, (n == 1));
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_mode = ~m; req0_data = ~d; req0_len = 8'd77;
    req1_mode = ~m; req1_data = ~d; req1_len = 8'd77;
  endtask

  // Follow a running command: len enable cycles, then the done cycle, then
  // one idle cycle. Optionally raise cnt_rco on the last RUN cycle only.
  task automatic observe(input int len, input int id, input logic [1:0] m,
                         input logic [3:0] d, input bit rco_last, input int exp_rco);
    for (int k = 0; k < len; k++) begin
      check("run_enable", cnt_enable, 1);
      check("run_mode", cnt_mode, m);
      check("run_D", cnt_D, d);
      check("run_done", done, 0);
      check("run_ready", {req0_ready, req1_ready}, 0);
      cnt_rco = rco_last && (k == len - 1);
      step();
    end
    cnt_rco = 1'b0;
    check("done_enable", cnt_enable, 0);
    check("done_pulse", done, 1);
    check("done_id", done_id, id);
    check("done_rco", done_rco, exp_rco);
    check("done_mode_hold", cnt_mode, m);
    check("done_D_hold", cnt_D, d);
    step();
    check("idle_done", done, 0);
    check("idle_enable", cnt_enable, 0);
  endtask

  initial begin
    reset = 1'b1; cnt_rco = 1'b0;
    req0_valid = 1'b0; req0_mode = 2'b00; req0_data = 4'h0; req0_len = '0;
    req1_valid = 1'b0; req1_mode = 2'b00; req1_data = 4'h0; req1_len = '0;
    do_reset();

    // Load command: length forced to 1.
    issue(0, 2'b11, 4'hA, 8'd5);
    observe(1, 0, 2'b11, 4'hA, 1'b0, 0);

    // Requester 1 alone, count +1 for 3 cycles.
    issue(1, 2'b10, 4'h3, 8'd3);
    observe(3, 1, 2'b10, 4'h3, 1'b0, 0);

    // Both valid continuously: grants alternate 0,1,0,1.
    req0_valid = 1'b1; req0_mode = 2'b10; req0_data = 4'h1; req0_len = 8'd2;
    req1_valid = 1'b1; req1_mode = 2'b01; req1_data = 4'h2; req1_len = 8'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_ready0", req0_ready, (i % 2 == 0));
      check("alt_ready1", req1_ready, (i % 2 == 1));
      step();
      if (i % 2 == 0) observe(2, 0, 2'b10, 4'h1, 1'b0, 0);
      else            observe(2, 1, 2'b01, 4'h2, 1'b0, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // rco only on the final RUN cycle is still reported; then rco never seen.
    issue(0, 2'b00, 4'h5, 8'd6);
    observe(6, 0, 2'b00, 4'h5, 1'b1, 1);
    issue(1, 2'b00, 4'h6, 8'd6);
    observe(6, 1, 2'b00, 4'h6, 1'b0, 0);

    // Length boundaries: 0 behaves as 1, 255 runs 255 cycles.
    issue(0, 2'b10, 4'h7, 8'd0);
    observe(1, 0, 2'b10, 4'h7, 1'b0, 0);
    issue(1, 2'b01, 4'h9, 8'd255);
    observe(255, 1, 2'b01, 4'h9, 1'b0, 0);

    // Reset on the third RUN cycle of a len-10 command aborts it.
    issue(0, 2'b10, 4'hC, 8'd10);
    check("abort_run1", cnt_enable, 1);
    step();
    check("abort_run2", cnt_enable, 1);
    step();
    check("abort_run3", cnt_enable, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_enable", cnt_enable, 0);
    check("abort_done", done, 0);
    step();
    check("abort_enable2", cnt_enable, 0);
    check("abort_done2", done, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_mode = 2'b10; req0_data = 4'h4; req0_len = 8'd1;
    req1_mode = 2'b01; req1_data = 4'h8; req1_len = 8'd1;
    #1;
    check("post_rst_ready0", req0_ready, 1);
    check("post_rst_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    observe(1, 0, 2'b10, 4'h4, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
